// File: rtl/riot_io_timer.sv
`default_nettype none
// ============================================================================
// Module      : riot_io_timer
// Description : RRIOT-style parallel I/O ports with per-port data/direction
//               registers, a prescaled interval timer and a port-0 MSB edge
//               detector, both able to raise an active-low interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module riot_io_timer #(
    parameter int NPORTS = 2,
    parameter int WIDTH  = 8
) (
    input  logic                    phi2,
    input  logic                    rst,
    input  logic                    cs,
    input  logic                    we_n,
    input  logic [4:0]              addr,
    input  logic [WIDTH-1:0]        di,
    // "do" is a SystemVerilog keyword, hence dout for the read-data bus
    output logic [WIDTH-1:0]        dout,
    output logic                    oe,
    input  logic [NPORTS*WIDTH-1:0] pai,
    output logic [NPORTS*WIDTH-1:0] pao,
    output logic [NPORTS*WIDTH-1:0] ddr,
    output logic                    irq_n
);

    localparam int                 c_PRE_W   = 10;
    localparam logic [WIDTH-1:0]   c_CNT_ONE = WIDTH'(1);
    localparam logic [c_PRE_W-1:0] c_PRE_ONE = c_PRE_W'(1);

    // Reload value (divide ratio minus one) for each prescaler select.
    function automatic logic [c_PRE_W-1:0] f_pre_reload(input logic [1:0] sel);
        logic [c_PRE_W-1:0] v;
        case (sel)
            2'b00:   v = c_PRE_W'(0);
            2'b01:   v = c_PRE_W'(7);
            2'b10:   v = c_PRE_W'(63);
            default: v = c_PRE_W'(1023);
        endcase
        return v;
    endfunction

    logic               w_wr;
    logic               w_rd;
    logic [2:0]         w_port;
    logic               w_port_wr;
    logic               w_tmr_wr;
    logic               w_tmr_rd;
    logic               w_ctl_wr;
    logic               w_sts_rd;
    logic               w_tick;
    logic               w_underflow;
    logic               w_cur;
    logic               w_edge;
    logic [WIDTH-1:0]   w_port_rdata;
    logic [WIDTH-1:0]   w_status;

    logic [WIDTH-1:0]   r_count;
    logic [c_PRE_W-1:0] r_pre;
    logic [1:0]         r_psel;
    logic               r_tie;
    logic               r_eie;
    logic               r_epol;
    logic               r_tflag;
    logic               r_eflag;
    logic               r_run;
    logic               r_prev;
    logic               r_irq_n;

    // ------------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------------
    assign w_wr      = cs & ~we_n;
    assign w_rd      = cs & we_n;
    assign oe        = w_rd;
    assign w_port    = addr[3:1];
    assign w_port_wr = w_wr & ~addr[4];
    assign w_tmr_wr  = w_wr & addr[4] & ~addr[2];
    assign w_tmr_rd  = w_rd & addr[4] & ~addr[2];
    assign w_ctl_wr  = w_wr & addr[4] & addr[2];
    assign w_sts_rd  = w_rd & addr[4] & addr[2];

    // ------------------------------------------------------------------------
    // Port registers; unimplemented port numbers never match a slot
    // ------------------------------------------------------------------------
    genvar gp;
    generate
        for (gp = 0; gp < NPORTS; gp++) begin : g_port
            logic [WIDTH-1:0] r_pao;
            logic [WIDTH-1:0] r_ddr;

            always_ff @(posedge phi2) begin
                if (rst) begin
                    r_pao <= '0;
                    r_ddr <= '0;
                end else if (w_port_wr && (w_port == 3'(gp))) begin
                    if (addr[0]) begin
                        r_ddr <= di;
                    end else begin
                        r_pao <= di;
                    end
                end
            end

            assign pao[gp*WIDTH +: WIDTH] = r_pao;
            assign ddr[gp*WIDTH +: WIDTH] = r_ddr;
        end
    endgenerate

    always_comb begin
        w_port_rdata = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (w_port == 3'(p)) begin
                if (addr[0]) begin
                    w_port_rdata = ddr[p*WIDTH +: WIDTH];
                end else begin
                    w_port_rdata = (pao[p*WIDTH +: WIDTH] &  ddr[p*WIDTH +: WIDTH])
                                 | (pai[p*WIDTH +: WIDTH] & ~ddr[p*WIDTH +: WIDTH]);
                end
            end
        end
    end

    assign w_status = {r_tflag, r_eflag, {(WIDTH-2){1'b0}}};

    always_comb begin
        if (!addr[4]) begin
            dout = w_port_rdata;
        end else if (!addr[2]) begin
            dout = r_count;
        end else begin
            dout = w_status;
        end
    end

    // ------------------------------------------------------------------------
    // Interval timer
    // ------------------------------------------------------------------------
    assign w_tick      = r_run & (r_pre == '0);
    assign w_underflow = w_tick & (r_count == '0);

    always_ff @(posedge phi2) begin
        if (rst) begin
            r_count <= '0;
            r_pre   <= '0;
            r_psel  <= '0;
            r_tie   <= 1'b0;
            r_tflag <= 1'b0;
            r_run   <= 1'b0;
        end else if (w_tmr_wr) begin
            // A load overrides any underflow happening in the same cycle.
            r_count <= di;
            r_psel  <= addr[1:0];
            r_tie   <= addr[3];
            r_pre   <= f_pre_reload(addr[1:0]);
            r_tflag <= 1'b0;
            r_run   <= 1'b1;
        end else begin
            if (w_tmr_rd) begin
                r_tie <= addr[3];
            end
            if (w_tick) begin
                r_count <= r_count - c_CNT_ONE;
                // Once flagged, the count keeps stepping at the input clock rate.
                r_pre   <= (r_tflag || w_underflow) ? '0 : f_pre_reload(r_psel);
            end else if (r_run) begin
                r_pre <= r_pre - c_PRE_ONE;
            end
            if (w_underflow) begin
                r_tflag <= 1'b1;
            end else if (w_tmr_rd) begin
                r_tflag <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Edge detector and interrupt output
    // ------------------------------------------------------------------------
    assign w_cur  = pai[WIDTH-1];
    assign w_edge = r_epol ? (~r_prev & w_cur) : (r_prev & ~w_cur);

    always_ff @(posedge phi2) begin
        // Tracking the pin through reset prevents a false edge at release.
        r_prev <= w_cur;
        if (rst) begin
            r_epol  <= 1'b0;
            r_eie   <= 1'b0;
            r_eflag <= 1'b0;
            r_irq_n <= 1'b1;
        end else begin
            if (w_ctl_wr) begin
                r_epol <= addr[0];
                r_eie  <= addr[1];
            end
            if (w_edge) begin
                r_eflag <= 1'b1;
            end else if (w_sts_rd) begin
                r_eflag <= 1'b0;
            end
            r_irq_n <= ~((r_tflag & r_tie) | (r_eflag & r_eie));
        end
    end

    assign irq_n = r_irq_n;

endmodule
`default_nettype wire

// File: tb/tb_riot_io_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_riot_io_timer
// Description : Directed and randomized bench for riot_io_timer with an
//               in-bench behavioural model of the register map and timer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riot_io_timer;

    localparam int NPORTS = 2;
    localparam int WIDTH  = 8;
    localparam int NB     = NPORTS * WIDTH;
    localparam int MASK   = (1 << WIDTH) - 1;

    logic             phi2 = 1'b0;
    logic             rst  = 1'b1;
    logic             cs   = 1'b0;
    logic             we_n = 1'b1;
    logic [4:0]       addr = '0;
    logic [WIDTH-1:0] di   = '0;
    logic [NB-1:0]    pai  = '0;
    logic [WIDTH-1:0] dout;
    logic             oe;
    logic [NB-1:0]    pao;
    logic [NB-1:0]    ddr;
    logic             irq_n;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    riot_io_timer #(.NPORTS(NPORTS), .WIDTH(WIDTH)) dut (
        .phi2  (phi2),
        .rst   (rst),
        .cs    (cs),
        .we_n  (we_n),
        .addr  (addr),
        .di    (di),
        .dout  (dout),
        .oe    (oe),
        .pai   (pai),
        .pao   (pao),
        .ddr   (ddr),
        .irq_n (irq_n)
    );

    initial forever #5 phi2 = ~phi2;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------------
    int m_pao [NPORTS];
    int m_ddr [NPORTS];
    int m_count, m_pre, m_div, m_tie, m_eie, m_epol, m_tflag, m_eflag, m_run, m_prev, m_irq_n;
    int div_tab [4] = '{1, 8, 64, 1024};

    function automatic int pin_of(input int p);
        return int'(pai >> (p * WIDTH)) & MASK;
    endfunction

    function automatic int exp_read();
        int a;
        int p;
        a = int'(addr);
        if (a < 16) begin
            p = a / 2;
            if (p >= NPORTS) return 0;
            if (a % 2 == 1) return m_ddr[p];
            return (m_pao[p] & m_ddr[p]) | (pin_of(p) & ~m_ddr[p] & MASK);
        end
        if ((a & 4) == 0) return m_count;
        return (m_tflag << (WIDTH - 1)) | (m_eflag << (WIDTH - 2));
    endfunction

    always @(posedge phi2) begin : model
        int a;
        bit wr, rd, cur, edge_seen, uf, irq_next;
        a   = int'(addr);
        wr  = cs && !we_n;
        rd  = cs && we_n;
        cur = pai[WIDTH-1];
        if (rst) begin
            for (int p = 0; p < NPORTS; p++) begin
                m_pao[p] = 0;
                m_ddr[p] = 0;
            end
            m_count = 0; m_pre = 0; m_div = 1; m_tie = 0; m_eie = 0; m_epol = 0;
            m_tflag = 0; m_eflag = 0; m_run = 0; m_prev = int'(cur); m_irq_n = 1;
        end else begin
            irq_next  = !((m_tflag != 0 && m_tie != 0) || (m_eflag != 0 && m_eie != 0));
            edge_seen = (m_epol != 0) ? (m_prev == 0 && cur) : (m_prev != 0 && !cur);
            if (wr && a < 16 && a / 2 < NPORTS) begin
                if (a % 2 == 1) m_ddr[a/2] = int'(di);
                else            m_pao[a/2] = int'(di);
            end
            if (wr && a >= 16 && (a & 4) == 0) begin
                m_count = int'(di);
                m_div   = div_tab[a & 3];
                m_tie   = (a >> 3) & 1;
                m_pre   = m_div - 1;
                m_tflag = 0;
                m_run   = 1;
            end else begin
                uf = 1'b0;
                if (m_run != 0) begin
                    if (m_pre > 0) begin
                        m_pre = m_pre - 1;
                    end else begin
                        uf      = (m_count == 0);
                        m_pre   = (m_tflag != 0 || uf) ? 0 : m_div - 1;
                        m_count = (m_count + MASK) & MASK;
                        if (uf) m_tflag = 1;
                    end
                end
                if (rd && a >= 16 && (a & 4) == 0) begin
                    m_tie = (a >> 3) & 1;
                    if (!uf) m_tflag = 0;
                end
            end
            if (wr && a >= 16 && (a & 4) != 0) begin
                m_epol = a & 1;
                m_eie  = (a >> 1) & 1;
            end
            if (edge_seen) m_eflag = 1;
            else if (rd && a >= 16 && (a & 4) != 0) m_eflag = 0;
            m_prev  = int'(cur);
            m_irq_n = int'(irq_next);
        end
    end

    always @(negedge phi2) begin : compare
        logic [NB-1:0] ep;
        logic [NB-1:0] ed;
        if (check_en) begin
            for (int p = 0; p < NPORTS; p++) begin
                ep[p*WIDTH +: WIDTH] = WIDTH'(m_pao[p]);
                ed[p*WIDTH +: WIDTH] = WIDTH'(m_ddr[p]);
            end
            check("pao", 64'(pao), 64'(ep));
            check("ddr", 64'(ddr), 64'(ed));
            check("irq_n", 64'(irq_n), 64'(m_irq_n));
            check("oe", 64'(oe), 64'(cs && we_n));
            if (cs && we_n) check("dout", 64'(dout), 64'(exp_read()));
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic cyc();
        @(posedge phi2);
        #1;
    endtask

    task automatic bus_wr(input logic [4:0] a, input logic [WIDTH-1:0] d);
        cs = 1'b1; we_n = 1'b0; addr = a; di = d;
        cyc();
        cs = 1'b0; we_n = 1'b1;
    endtask

    task automatic bus_rd(input logic [4:0] a, output logic [WIDTH-1:0] v);
        cs = 1'b1; we_n = 1'b1; addr = a;
        #1;
        v = dout;
        cyc();
        cs = 1'b0;
    endtask

    initial begin : stim
        logic [WIDTH-1:0] v;
        int n;

        pai = 16'h003C;
        rst = 1'b1;
        repeat (3) cyc();
        check_en = 1'b1;
        rst = 1'b0;
        check("rst_irq_n", 64'(irq_n), 64'(1));
        check("rst_pao", 64'(pao), 64'(0));
        check("rst_ddr", 64'(ddr), 64'(0));
        bus_rd(5'b10100, v); check("rst_status", 64'(v), 64'(0));
        bus_rd(5'b10000, v); check("rst_count", 64'(v), 64'(0));

        // Port read-back mixes output and input bits by direction
        bus_wr(5'b00001, 8'hF0);
        bus_wr(5'b00000, 8'hA5);
        check("pao0", 64'(pao[7:0]), 64'(8'hA5));
        check("ddr0", 64'(ddr[7:0]), 64'(8'hF0));
        bus_rd(5'b00000, v); check("port0_read", 64'(v), 64'(8'hAC));
        bus_wr(5'b00100, 8'h55);
        check("p2_wr_pao", 64'(pao), 64'(16'h00A5));
        check("p2_wr_ddr", 64'(ddr), 64'(16'h00F0));
        bus_rd(5'b00100, v); check("p2_read", 64'(v), 64'(0));

        // Timer divide-by-8, load 3, interrupt enabled
        bus_wr(5'b11001, 8'h03);
        n = 0;
        while (irq_n && n < 100) begin
            @(posedge phi2);
            n++;
            @(negedge phi2);
        end
        check("irq_latency_div8", 64'(n), 64'(33));
        #2;
        bus_rd(5'b10000, v); check("count_after_uf", 64'(v), 64'(8'hFE));
        cyc();
        check("irq_clear_after_read", 64'(irq_n), 64'(1));

        // Read coincident with underflow keeps the flag
        bus_wr(5'b10000, 8'h00);
        bus_rd(5'b10000, v); check("read_at_uf", 64'(v), 64'(0));
        bus_rd(5'b10100, v); check("tflag_kept", 64'(v), 64'(8'h80));

        // Rising-edge detector
        bus_wr(5'b10011, 8'hFF);
        bus_wr(5'b10111, 8'h00);
        pai = 16'h00BC;
        cyc(); check("edge_irq_lat", 64'(irq_n), 64'(1));
        cyc(); check("edge_irq", 64'(irq_n), 64'(0));
        bus_rd(5'b10100, v); check("edge_status", 64'(v), 64'(8'h40));
        cyc(); check("edge_irq_clr", 64'(irq_n), 64'(1));
        pai = 16'h003C;
        cyc(); cyc();
        check("fall_no_irq", 64'(irq_n), 64'(1));
        bus_rd(5'b10100, v); check("fall_no_flag", 64'(v), 64'(0));

        // Load in the underflow cycle wins
        bus_wr(5'b10001, 8'h00);
        repeat (7) cyc();
        bus_wr(5'b10001, 8'h10);
        bus_rd(5'b10000, v); check("load_wins_count", 64'(v), 64'(8'h10));
        bus_rd(5'b10100, v); check("load_wins_flag", 64'(v), 64'(0));

        // Reset mid-countdown with interrupt asserted
        bus_wr(5'b11000, 8'h02);
        n = 0;
        while (irq_n && n < 20) begin
            @(posedge phi2);
            n++;
            @(negedge phi2);
        end
        check("irq_latency_div1", 64'(n), 64'(4));
        #2;
        rst = 1'b1;
        pai = 16'h00BC;
        repeat (3) cyc();
        rst = 1'b0;
        check("rst2_irq_n", 64'(irq_n), 64'(1));
        check("rst2_pao", 64'(pao), 64'(0));
        check("rst2_ddr", 64'(ddr), 64'(0));
        bus_wr(5'b10111, 8'h00);
        repeat (3) cyc();
        check("rst2_no_edge", 64'(irq_n), 64'(1));
        bus_rd(5'b10100, v); check("rst2_status", 64'(v), 64'(0));
        repeat (5) cyc();
        bus_rd(5'b10000, v); check("timer_stopped", 64'(v), 64'(0));

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            cs   = ($urandom_range(0, 3) == 0);
            we_n = 1'($urandom_range(0, 1));
            addr = 5'($urandom);
            di   = 8'($urandom);
            if (cs && !we_n && addr[4] && !addr[2] && $urandom_range(0, 1) == 1)
                di = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 7) == 0) pai = 16'($urandom);
            rst = ($urandom_range(0, 599) == 0);
            cyc();
        end
        rst = 1'b0; cs = 1'b0; we_n = 1'b1;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
